// File: rtl/mem_responder.sv
// mem_responder: LC-3 memory-side responder on the MAR/MDR bus.
// Program/data RAM plus one MMIO word, with wait states and a ready pulse.
module mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic [15:0] MAR,
  input  logic [15:0] Data_from_CPU,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [15:0] SW,
  output logic [15:0] Data_to_CPU,
  output logic        R,
  output logic [15:0] HEX_out,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS_LOAD =
    4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_RELEASE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        op_wr;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [15:0] ram [DEPTH];

  logic        capture;
  logic        op_cur;
  logic [15:0] addr_cur;
  logic        is_io;
  logic        in_ram;
  logic [15:0] rdata;
  logic        r_nx;
  logic        dout_load;
  logic        hex_we;
  logic        ram_we;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset_ah) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; RELEASE waits for both requests low
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (rd_req || wr_req)
          state_nx = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:
        if (cnt == 4'd0) state_nx = S_RESP;
      S_RESP:
        state_nx = S_RELEASE;
      S_RELEASE:
        if (!rd_req && !wr_req) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Output/decode logic; the live request is used on the capture cycle
  always_comb begin
    capture   = (state == S_IDLE) && (rd_req || wr_req);
    op_cur    = capture ? wr_req : op_wr;
    addr_cur  = capture ? MAR : addr_q;
    is_io     = (addr_cur == IO_ADDR);
    in_ram    = ((addr_cur >> ADDR_W) == 16'd0);
    rdata     = 16'h0000;
    if (is_io)       rdata = sw_sync;
    else if (in_ram) rdata = ram[addr_cur[ADDR_W-1:0]];
    r_nx      = (state == S_RESP);
    dout_load = (state_nx == S_RESP) && !op_cur;
    hex_we    = (state == S_RESP) && op_wr && is_io;
    ram_we    = (state == S_RESP) && op_wr && !is_io
                && in_ram && !Reset_ah;
  end

  // Request capture, wait counter and sticky error
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      cnt     <= 4'd0;
      err     <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      op_wr   <= 1'b0;
    end else if (capture) begin
      cnt     <= WS_LOAD;
      addr_q  <= MAR;
      wdata_q <= Data_from_CPU;
      op_wr   <= wr_req;
      if (rd_req && wr_req) err <= 1'b1;
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Registered ready pulse and read data
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      R           <= 1'b0;
      Data_to_CPU <= 16'h0000;
    end else begin
      R <= r_nx;
      if (dout_load) Data_to_CPU <= rdata;
    end
  end

  // Hex display register, written at the end of RESP
  always_ff @(posedge Clk) begin
    if (Reset_ah)    HEX_out <= 16'h0000;
    else if (hex_we) HEX_out <= wdata_q;
  end

  // RAM write port; contents survive reset
  always_ff @(posedge Clk) begin
    if (ram_we) ram[addr_q[ADDR_W-1:0]] <= wdata_q;
  end

  // Two-flop synchronizer for the board switches
  always_ff @(posedge Clk) begin
    sw_meta <= SW;
    sw_sync <= sw_meta;
  end

endmodule
